// File: rtl/pcie_aurora_64b66b_frame_tx_pkg.sv
// Shared frame constants for the Aurora 64B66B TX framer and RX parser.
package pcie_aurora_64b66b_frame_tx_pkg;

    localparam logic [15:0] FRAME_HDR_MAGIC = 16'h55aa;

    localparam logic [15:0] FRAME_CMD_CTRL  = 16'h0001;
    localparam logic [15:0] FRAME_CMD_EDS   = 16'h0002;
    localparam logic [15:0] FRAME_CMD_ENC   = 16'h0003;
    localparam logic [15:0] FRAME_CMD_FBC   = 16'h0004;

    localparam logic [1:0] CTRL_CODE_EDS_END   = 2'd0;
    localparam logic [1:0] CTRL_CODE_EDS_START = 2'd1;
    localparam logic [1:0] CTRL_CODE_FBC_START = 2'd2;
    localparam logic [1:0] CTRL_CODE_FBC_END   = 2'd3;

    // One-hot framer states
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_HDR   = 5'b00010;
    localparam logic [4:0] ST_CHECK = 5'b00100;
    localparam logic [4:0] ST_ENC   = 5'b01000;
    localparam logic [4:0] ST_DATA  = 5'b10000;

    function automatic logic [63:0] frame_hdr(input logic [15:0] cmd);
        return {32'h0, FRAME_HDR_MAGIC, cmd};
    endfunction

    // Lowest-numbered pending control code wins
    function automatic logic [1:0] lowest_code(input logic [3:0] pend);
        logic [1:0] code;
        code = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) code = 2'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/aurora_link_ready_dly.sv
// Qualifies CHANNEL_UP: link_ok_o rises after 16 consecutive high cycles.
module aurora_link_ready_dly (
    input  logic USER_CLK,
    input  logic RESET_N,
    input  logic CHANNEL_UP,
    output logic link_ok_o
);

    logic [4:0] cnt_q;

    // Count up while the channel is up, saturate once bit 4 is set
    always_ff @(posedge USER_CLK) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (!CHANNEL_UP) begin
            cnt_q <= '0;
        end else if (!cnt_q[4]) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign link_ok_o = cnt_q[4];

endmodule

// File: rtl/pcie_aurora_64b66b_frame_tx.sv
// TX framer for the Aurora 64B66B user AXI-stream: control, encoder and
// EDS/FBC data frames, one at a time, each led by a 55aa_000X header beat.
// Optional: define FRAME_TX_DROP_CNT_EN to add ctrl_drop_cnt_o.
module pcie_aurora_64b66b_frame_tx
    import pcie_aurora_64b66b_frame_tx_pkg::*;
#(
    parameter int unsigned EDS_PKG_LENGTH = 1026
) (
    input  logic        USER_CLK,
    input  logic        RESET_N,
    input  logic        CHANNEL_UP,
    input  logic        eds_start_i,
    input  logic        eds_end_i,
    input  logic        fbc_start_i,
    input  logic        fbc_end_i,
    input  logic        enc_wr_i,
    input  logic [63:0] enc_data_i,
    input  logic        pkg_avail_i,
    input  logic        fbc_mode_i,
    input  logic        eds_tvalid_i,
    input  logic [63:0] eds_tdata_i,
    output logic        eds_tready_o,
    output logic        tx_tvalid_o,
    output logic [63:0] tx_tdata_o,
    output logic [7:0]  tx_tkeep_o,
    output logic        tx_tlast_o,
    input  logic        tx_tready_i,
    output logic        busy_o,
    output logic        frame_abort_o
`ifdef FRAME_TX_DROP_CNT_EN
    ,
    output logic [15:0] ctrl_drop_cnt_o
`endif
);

    localparam logic [15:0] PKG_LEN = 16'(EDS_PKG_LENGTH);

    logic        link_ok;
    logic [4:0]  state_q, state_d;
    logic [4:0]  payload_st_q, payload_st_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  ctrl_req, ctrl_clr;
    logic [1:0]  code_q, code_d;
    logic        enc_pend_q, enc_pend_d;
    logic [63:0] enc_latch_q, enc_latch_d;
    logic        enc_take, enc_restore;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        abort_q, abort_d;
    logic        hs, can_load, data_left;

    aurora_link_ready_dly u_link_ready_dly (
        .USER_CLK   (USER_CLK),
        .RESET_N    (RESET_N),
        .CHANNEL_UP (CHANNEL_UP),
        .link_ok_o  (link_ok)
    );

    assign hs        = tvalid_q & tx_tready_i;
    assign can_load  = ~tvalid_q | tx_tready_i;
    assign data_left = beat_cnt_q < PKG_LEN;

    assign eds_tready_o  = (state_q == ST_DATA) & data_left & can_load;
    assign tx_tvalid_o   = tvalid_q;
    assign tx_tdata_o    = tdata_q;
    assign tx_tlast_o    = tlast_q;
    assign tx_tkeep_o    = 8'hFF;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_abort_o = abort_q;

    // Map request pulses onto their control-code bit positions
    always_comb begin
        ctrl_req = '0;
        ctrl_req[CTRL_CODE_EDS_END]   = eds_end_i;
        ctrl_req[CTRL_CODE_EDS_START] = eds_start_i;
        ctrl_req[CTRL_CODE_FBC_START] = fbc_start_i;
        ctrl_req[CTRL_CODE_FBC_END]   = fbc_end_i;
    end

    // Framer FSM and registered AXI output beat
    always_comb begin
        state_d      = state_q;
        payload_st_d = payload_st_q;
        code_d       = code_q;
        beat_cnt_d   = beat_cnt_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        abort_d      = 1'b0;
        ctrl_clr     = '0;
        enc_take     = 1'b0;
        enc_restore  = 1'b0;

        if ((state_q != ST_IDLE) && !link_ok) begin
            // Link lost: drop the frame; control flags stay set for a retry
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            abort_d     = 1'b1;
            beat_cnt_d  = '0;
            enc_restore = (state_q == ST_ENC);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    beat_cnt_d = '0;
                    tvalid_d   = 1'b0;
                    tlast_d    = 1'b0;
                    if (link_ok) begin
                        if (|pend_q) begin
                            code_d       = lowest_code(pend_q);
                            payload_st_d = ST_CHECK;
                            tdata_d      = frame_hdr(FRAME_CMD_CTRL);
                            tvalid_d     = 1'b1;
                            state_d      = ST_HDR;
                        end else if (enc_pend_q) begin
                            payload_st_d = ST_ENC;
                            tdata_d      = frame_hdr(FRAME_CMD_ENC);
                            tvalid_d     = 1'b1;
                            state_d      = ST_HDR;
                        end else if (pkg_avail_i) begin
                            payload_st_d = ST_DATA;
                            tdata_d      = frame_hdr(fbc_mode_i ? FRAME_CMD_FBC : FRAME_CMD_EDS);
                            tvalid_d     = 1'b1;
                            state_d      = ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (hs) begin
                        state_d = payload_st_q;
                        if (payload_st_q == ST_CHECK) begin
                            tdata_d = {62'h0, code_q};
                            tlast_d = 1'b1;
                        end else if (payload_st_q == ST_ENC) begin
                            tdata_d  = enc_latch_q;
                            tlast_d  = 1'b1;
                            enc_take = 1'b1;
                        end else begin
                            tvalid_d = 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (hs) begin
                        ctrl_clr[code_q] = 1'b1;
                        state_d          = ST_IDLE;
                        tvalid_d         = 1'b0;
                        tlast_d          = 1'b0;
                    end
                end
                ST_ENC: begin
                    if (hs) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (!data_left) begin
                        if (hs) begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else if (can_load) begin
                        // Source gaps leave the output empty rather than repeat a word
                        tvalid_d = eds_tvalid_i;
                        if (eds_tvalid_i) begin
                            tdata_d    = eds_tdata_i;
                            beat_cnt_d = beat_cnt_q + 16'd1;
                            tlast_d    = (beat_cnt_q + 16'd1 == PKG_LEN);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
            endcase
        end
    end

    // Request flags: a request in the same cycle as its clear re-arms the flag.
    // The encoder flag drops once the latch is copied into the output beat.
    always_comb begin
        pend_d      = (pend_q & ~ctrl_clr) | ctrl_req;
        enc_pend_d  = (enc_pend_q & ~enc_take) | enc_wr_i | enc_restore;
        enc_latch_d = enc_wr_i ? enc_data_i : enc_latch_q;
    end

    // State and output registers
    always_ff @(posedge USER_CLK) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            payload_st_q <= ST_CHECK;
            code_q       <= '0;
            pend_q       <= '0;
            enc_pend_q   <= 1'b0;
            enc_latch_q  <= '0;
            beat_cnt_q   <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            payload_st_q <= payload_st_d;
            code_q       <= code_d;
            pend_q       <= pend_d;
            enc_pend_q   <= enc_pend_d;
            enc_latch_q  <= enc_latch_d;
            beat_cnt_q   <= beat_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            abort_q      <= abort_d;
        end
    end

`ifdef FRAME_TX_DROP_CNT_EN
    logic [3:0]  ctrl_drop;
    logic        enc_drop;
    logic [2:0]  drop_inc;
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign ctrl_drop = ctrl_req & pend_q & ~ctrl_clr;
    assign enc_drop  = enc_wr_i & enc_pend_q & ~enc_take;

    // Saturating count of merged control pulses and overwritten encoder words
    always_comb begin
        drop_inc = {2'b0, ctrl_drop[0]} + {2'b0, ctrl_drop[1]} + {2'b0, ctrl_drop[2]}
                 + {2'b0, ctrl_drop[3]} + {2'b0, enc_drop};
        drop_sum   = {1'b0, drop_cnt_q} + {14'b0, drop_inc};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Drop counter register
    always_ff @(posedge USER_CLK) begin
        if (!RESET_N) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ctrl_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_aurora_64b66b_frame_tx.sv
// Self-checking bench for pcie_aurora_64b66b_frame_tx.
module tb_pcie_aurora_64b66b_frame_tx;

    localparam int LEN = 1026;

    logic        USER_CLK = 1'b0;
    logic        RESET_N;
    logic        CHANNEL_UP;
    logic        eds_start_i, eds_end_i, fbc_start_i, fbc_end_i;
    logic        enc_wr_i;
    logic [63:0] enc_data_i;
    logic        pkg_avail_i, fbc_mode_i;
    logic        eds_tvalid_i;
    logic [63:0] eds_tdata_i;
    logic        eds_tready_o;
    logic        tx_tvalid_o;
    logic [63:0] tx_tdata_o;
    logic [7:0]  tx_tkeep_o;
    logic        tx_tlast_o;
    logic        tx_tready_i;
    logic        busy_o;
    logic        frame_abort_o;
`ifdef FRAME_TX_DROP_CNT_EN
    logic [15:0] ctrl_drop_cnt_o;
`endif

    pcie_aurora_64b66b_frame_tx #(
        .EDS_PKG_LENGTH (LEN)
    ) dut (
        .USER_CLK      (USER_CLK),
        .RESET_N       (RESET_N),
        .CHANNEL_UP    (CHANNEL_UP),
        .eds_start_i   (eds_start_i),
        .eds_end_i     (eds_end_i),
        .fbc_start_i   (fbc_start_i),
        .fbc_end_i     (fbc_end_i),
        .enc_wr_i      (enc_wr_i),
        .enc_data_i    (enc_data_i),
        .pkg_avail_i   (pkg_avail_i),
        .fbc_mode_i    (fbc_mode_i),
        .eds_tvalid_i  (eds_tvalid_i),
        .eds_tdata_i   (eds_tdata_i),
        .eds_tready_o  (eds_tready_o),
        .tx_tvalid_o   (tx_tvalid_o),
        .tx_tdata_o    (tx_tdata_o),
        .tx_tkeep_o    (tx_tkeep_o),
        .tx_tlast_o    (tx_tlast_o),
        .tx_tready_i   (tx_tready_i),
        .busy_o        (busy_o),
        .frame_abort_o (frame_abort_o)
`ifdef FRAME_TX_DROP_CNT_EN
        ,
        .ctrl_drop_cnt_o (ctrl_drop_cnt_o)
`endif
    );

    always #5 USER_CLK = ~USER_CLK;

    localparam logic [63:0] H1 = 64'h0000_0000_55aa_0001;
    localparam logic [63:0] H2 = 64'h0000_0000_55aa_0002;
    localparam logic [63:0] H3 = 64'h0000_0000_55aa_0003;
    localparam logic [63:0] H4 = 64'h0000_0000_55aa_0004;
    localparam logic [63:0] WA = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] WB = 64'h5A5A_5A5A_5A5A_5A5A;

    typedef struct {
        logic [3:0]  ctrl;      // {fbc_end, fbc_start, eds_start, eds_end}
        logic        enc_wr;
        logic [63:0] enc_data;
        logic        tready;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;
    logic [63:0] acc_data [0:1099];
    logic        acc_last [0:1099];
    int          n_acc;
    logic [15:0] src_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; leave the time point 1 unit after the edge
    task automatic tick();
        @(posedge USER_CLK);
        #1;
    endtask

    // One cycle with sampling of the handshake and source pop before the edge
    task automatic stream_cycle();
        logic popped;
        #2;
        if (tx_tvalid_o && tx_tready_i && n_acc < 1100) begin
            acc_data[n_acc] = tx_tdata_o;
            acc_last[n_acc] = tx_tlast_o;
            n_acc++;
        end
        popped = eds_tready_o && eds_tvalid_i;
        @(posedge USER_CLK);
        #1;
        if (popped) src_cnt++;
    endtask

    initial begin
        int early;
        int bad_data, bad_last;
        bit w1, w2;

        vecs[0]  = '{4'b0101, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, H1,        1'b0, 1'b1};
        vecs[2]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h0,     1'b1, 1'b1};
        vecs[3]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, H1,        1'b0, 1'b1};
        vecs[5]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2,     1'b1, 1'b1};
        vecs[6]  = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[7]  = '{4'b1000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b0, 64'h0, 1'b0, 1'b1, H1,        1'b0, 1'b1};
        vecs[9]  = '{4'b0000, 1'b0, 64'h0, 1'b0, 1'b1, H1,        1'b0, 1'b1};
        vecs[10] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h3,     1'b1, 1'b1};
        vecs[11] = '{4'b1000, 1'b0, 64'h0, 1'b0, 1'b1, 64'h3,     1'b1, 1'b1};
        vecs[12] = '{4'b1000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[13] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, H1,        1'b0, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h3,     1'b1, 1'b1};
        vecs[15] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[16] = '{4'b0000, 1'b1, WA,    1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[17] = '{4'b0000, 1'b1, 64'h1111, 1'b1, 1'b1, H3,     1'b0, 1'b1};
        vecs[18] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1111,  1'b1, 1'b1};
        vecs[19] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[20] = '{4'b0010, 1'b1, 64'h2222, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0};
        vecs[21] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, H1,        1'b0, 1'b1};
        vecs[22] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1,     1'b1, 1'b1};
        vecs[23] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};
        vecs[24] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, H3,        1'b0, 1'b1};
        vecs[25] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2222,  1'b1, 1'b1};
        vecs[26] = '{4'b0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0,     1'b0, 1'b0};

        RESET_N = 1'b0; CHANNEL_UP = 1'b1;
        eds_start_i = 1'b0; eds_end_i = 1'b0; fbc_start_i = 1'b0; fbc_end_i = 1'b0;
        enc_wr_i = 1'b0; enc_data_i = '0; pkg_avail_i = 1'b0; fbc_mode_i = 1'b0;
        eds_tvalid_i = 1'b0; eds_tdata_i = '0; tx_tready_i = 1'b1;
        src_cnt = '0; n_acc = 0;

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 64'(tx_tvalid_o), 64'h0);
        check("rst_tdata", tx_tdata_o, 64'h0);
        check("rst_tlast", 64'(tx_tlast_o), 64'h0);
        check("rst_tkeep", 64'(tx_tkeep_o), 64'hFF);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_abort", 64'(frame_abort_o), 64'h0);
        check("rst_eds_tready", 64'(eds_tready_o), 64'h0);
`ifdef FRAME_TX_DROP_CNT_EN
        check("rst_drop_cnt", 64'(ctrl_drop_cnt_o), 64'h0);
`endif

        // Request right at release: nothing until the link qualifier matures
        RESET_N = 1'b1; eds_start_i = 1'b1;
        tick();
        eds_start_i = 1'b0;
        early = tx_tvalid_o ? 1 : 0;
        for (int k = 2; k <= 16; k++) begin
            tick();
            if (tx_tvalid_o) early++;
        end
        check("no_valid_before_link_ok", 64'(early), 64'h0);
        tick();
        check("t2_hdr_valid", 64'(tx_tvalid_o), 64'h1);
        check("t2_hdr_data", tx_tdata_o, H1);
        check("t2_hdr_last", 64'(tx_tlast_o), 64'h0);
        check("t2_busy_1", 64'(busy_o), 64'h1);
        tick();
        check("t2_code_data", tx_tdata_o, 64'h1);
        check("t2_code_last", 64'(tx_tlast_o), 64'h1);
        check("t2_busy_2", 64'(busy_o), 64'h1);
        tick();
        check("t2_end_valid", 64'(tx_tvalid_o), 64'h0);
        check("t2_end_busy", 64'(busy_o), 64'h0);

        // Table: simultaneous requests, backpressure, merge, re-arm, encoder
        for (int i = 0; i < NV; i++) begin
            {fbc_end_i, fbc_start_i, eds_start_i, eds_end_i} = vecs[i].ctrl;
            enc_wr_i    = vecs[i].enc_wr;
            enc_data_i  = vecs[i].enc_data;
            tx_tready_i = vecs[i].tready;
            tick();
            {fbc_end_i, fbc_start_i, eds_start_i, eds_end_i} = 4'b0;
            enc_wr_i = 1'b0;
            check($sformatf("vec%0d_valid", i), 64'(tx_tvalid_o), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), tx_tdata_o, vecs[i].exp_data);
                check($sformatf("vec%0d_last", i), 64'(tx_tlast_o), 64'(vecs[i].exp_last));
            end
        end
`ifdef FRAME_TX_DROP_CNT_EN
        check("drop_cnt_after_table", 64'(ctrl_drop_cnt_o), 64'd2);
`endif

        // EDS data frame with random backpressure and source gaps; two encoder
        // writes land mid-frame, only the latest must follow the data frame
        pkg_avail_i = 1'b1; fbc_mode_i = 1'b0; n_acc = 0; w1 = 0; w2 = 0;
        for (int cyc = 0; cyc < 20000 && n_acc < LEN + 3; cyc++) begin
            tx_tready_i  = 1'($urandom_range(1, 0));
            eds_tvalid_i = ($urandom_range(3, 0) != 0);
            eds_tdata_i  = 64'(src_cnt);
            enc_wr_i     = 1'b0;
            if (n_acc >= 300 && !w1) begin
                enc_wr_i = 1'b1; enc_data_i = WA; w1 = 1;
            end else if (n_acc >= 600 && !w2) begin
                enc_wr_i = 1'b1; enc_data_i = WB; w2 = 1;
            end
            stream_cycle();
            if (n_acc >= 1) pkg_avail_i = 1'b0;
        end
        enc_wr_i = 1'b0; eds_tvalid_i = 1'b0;
        check("t4_beat_count", 64'(n_acc), 64'(LEN + 3));
        if (n_acc == LEN + 3) begin
            check("t4_hdr", acc_data[0], H2);
            check("t4_hdr_last", 64'(acc_last[0]), 64'h0);
            bad_data = 0; bad_last = 0;
            for (int j = 1; j <= LEN; j++) begin
                if (acc_data[j] !== 64'(j - 1)) bad_data++;
                if (acc_last[j] !== (j == LEN)) bad_last++;
            end
            check("t4_payload_order", 64'(bad_data), 64'h0);
            check("t4_tlast_position", 64'(bad_last), 64'h0);
            check("t5_enc_hdr", acc_data[LEN + 1], H3);
            check("t5_enc_word", acc_data[LEN + 2], WB);
            check("t5_enc_last", 64'(acc_last[LEN + 2]), 64'h1);
        end

        // FBC frame cut by link loss after payload beat 100
        tick(); tick();
        tx_tready_i = 1'b1; eds_tvalid_i = 1'b1; pkg_avail_i = 1'b1; fbc_mode_i = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 2000 && n_acc < 101; cyc++) begin
            eds_tdata_i = 64'(src_cnt);
            stream_cycle();
            if (n_acc >= 1) pkg_avail_i = 1'b0;
        end
        check("t6_beats_before_cut", 64'(n_acc), 64'd101);
        check("t6_hdr", acc_data[0], H4);
        CHANNEL_UP = 1'b0; pkg_avail_i = 1'b0;
        tick();
        check("t6_still_busy", 64'(busy_o), 64'h1);
        check("t6_no_early_abort", 64'(frame_abort_o), 64'h0);
        tick();
        check("t6_abort_pulse", 64'(frame_abort_o), 64'h1);
        check("t6_abort_tvalid", 64'(tx_tvalid_o), 64'h0);
        check("t6_abort_idle", 64'(busy_o), 64'h0);
        tick();
        check("t6_abort_one_cycle", 64'(frame_abort_o), 64'h0);
        eds_tvalid_i = 1'b0;

        // Control frame aborted in its header keeps its flag and is resent
        CHANNEL_UP = 1'b1; tx_tready_i = 1'b0;
        repeat (17) tick();
        eds_end_i = 1'b1;
        tick();
        eds_end_i = 1'b0;
        tick();
        check("t6c_hdr_held", tx_tdata_o, H1);
        CHANNEL_UP = 1'b0;
        tick();
        tick();
        check("t6c_abort", 64'(frame_abort_o), 64'h1);
        eds_start_i = 1'b1;
        tick();
        eds_start_i = 1'b0;
        tick();
        eds_start_i = 1'b1;
        tick();
        eds_start_i = 1'b0;
`ifdef FRAME_TX_DROP_CNT_EN
        check("drop_cnt_final", 64'(ctrl_drop_cnt_o), 64'd4);
`endif
        CHANNEL_UP = 1'b1; tx_tready_i = 1'b1; n_acc = 0;
        for (int cyc = 0; cyc < 60; cyc++) stream_cycle();
        check("t6c_resend_count", 64'(n_acc), 64'd4);
        if (n_acc == 4) begin
            check("t6c_resend_hdr0", acc_data[0], H1);
            check("t6c_resend_code0", acc_data[1], 64'h0);
            check("t6c_resend_hdr1", acc_data[2], H1);
            check("t6c_resend_code1", acc_data[3], 64'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
